// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipelined processor front end: datapath width,
// the bubble instruction, the default reset PC, the sequential PC step, the
// IF/ID pipeline register layout and the next-PC source selector.
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int                XLEN             = 32;
   localparam logic [XLEN-1:0]   NOP_WORD         = 32'h0000_0000;
   localparam logic [XLEN-1:0]   DEFAULT_RESET_PC = 32'd100;
   localparam logic [XLEN-1:0]   PC_INC           = 32'd4;

   // Contents of the IF/ID pipeline register handed to decode.
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc4;
      logic            valid;
   } ifid_t;

   // Source of the next PC value, in decreasing priority order.
   typedef enum logic [1:0] {
      PC_SEL_BRANCH,
      PC_SEL_JUMP,
      PC_SEL_HOLD,
      PC_SEL_SEQ
   } pc_sel_e;

   // Pipeline bubble: the value IF/ID takes on reset or when squashed.
   function automatic ifid_t ifid_bubble();
      ifid_t b;
      b.instr = NOP_WORD;
      b.pc4   = '0;
      b.valid = 1'b0;
      return b;
   endfunction

endpackage : cpu_pkg

// File: rtl/ifid_reg.sv
// ---------------------------------------------------------------------------
// ifid_reg
// IF/ID pipeline register. Priority, highest first: reset, bubble, hold, load.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (loads a bubble)
//   i_bubble   in   squash: write a bubble (redirect or flush)
//   i_hold     in   stall: keep current contents
//   i_instr    in   fetched instruction word to capture
//   i_pc4      in   PC+4 of the fetched instruction
//   o_instr    out  registered instruction
//   o_pc4      out  registered PC+4
//   o_valid    out  1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module ifid_reg
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_bubble,
   input  logic            i_hold,
   input  logic [XLEN-1:0] i_instr,
   input  logic [XLEN-1:0] i_pc4,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_pc4,
   output logic            o_valid
);

   ifid_t r_ifid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst || i_bubble) begin
         r_ifid <= ifid_bubble();
      end else if (!i_hold) begin
         r_ifid.instr <= i_instr;
         r_ifid.pc4   <= i_pc4;
         r_ifid.valid <= 1'b1;
      end
   end

   assign o_instr = r_ifid.instr;
   assign o_pc4   = r_ifid.pc4;
   assign o_valid = r_ifid.valid;

endmodule : ifid_reg

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: holds the PC, presents it to the combinational
// big-endian instruction memory and captures the returned word into IF/ID.
// Applies stall, flush, taken-branch and jump redirects from later stages.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   stall          in   hold PC and IF/ID
//   flush          in   write a bubble into IF/ID (PC unaffected)
//   branch_taken   in   taken branch resolved in EX (beats jump: older)
//   branch_target  in   branch target byte address
//   jump           in   j/jal/jr resolved in ID
//   jump_target    in   jump target byte address
//   imem_addr      out  PC register, to instruction memory
//   imem_data      in   instruction word at imem_addr, same cycle
//   ifid_instr     out  registered instruction for decode
//   ifid_pc4       out  registered PC+4 of that instruction
//   ifid_valid     out  1 = real instruction, 0 = bubble
//   pc             out  PC register, for debug
// ---------------------------------------------------------------------------
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_target,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_data,
   output logic [XLEN-1:0] ifid_instr,
   output logic [XLEN-1:0] ifid_pc4,
   output logic            ifid_valid,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_pc_next;
   pc_sel_e         w_pc_sel;
   logic            w_squash;

   // Wraps naturally modulo 2^32.
   assign w_pc_plus4 = r_pc + PC_INC;

   // Any redirect overrides a stall; the in-flight word is wrong-path.
   assign w_squash = branch_taken | jump | flush;

   // NOTE: combinational blocks assign a default first so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      w_pc_sel = PC_SEL_SEQ;
      if (branch_taken)   w_pc_sel = PC_SEL_BRANCH;
      else if (jump)      w_pc_sel = PC_SEL_JUMP;
      else if (stall)     w_pc_sel = PC_SEL_HOLD;
   end

   always_comb begin
      w_pc_next = w_pc_plus4;
      unique case (w_pc_sel)
         PC_SEL_BRANCH: w_pc_next = branch_target;
         PC_SEL_JUMP:   w_pc_next = jump_target;
         PC_SEL_HOLD:   w_pc_next = r_pc;
         PC_SEL_SEQ:    w_pc_next = w_pc_plus4;
         default:       w_pc_next = w_pc_plus4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_pc <= RESET_PC;
      else     r_pc <= w_pc_next;
   end

   assign imem_addr = r_pc;
   assign pc        = r_pc;

   ifid_reg u_ifid_reg (
      .clk      (clk),
      .rst      (rst),
      .i_bubble (w_squash),
      .i_hold   (stall),
      .i_instr  (imem_data),
      .i_pc4    (w_pc_plus4),
      .o_instr  (ifid_instr),
      .o_pc4    (ifid_pc4),
      .o_valid  (ifid_valid)
   );

endmodule : fetch_stage
